// File: rtl/e203_exu_alu_dpath_arb.sv
// ---------------------------------------------------------------------------
// e203_exu_alu_dpath_arb
//
// Arbiter for the EXU ALU's shared datapath resources. Two requesters use
// these resources:
//   - single-cycle ALU operations
//   - the multi-cycle MULDIV sequencer
// The resources are the shared adder and the two shared buffer registers
// (sbf_0 / sbf_1).
//
// While a MULDIV operation is in flight, the datapath is locked to MULDIV.
// The lock is released by the final MULDIV step (done) or by a pipeline
// flush. A small starvation counter guarantees that a pending MULDIV start
// eventually wins over back-to-back ALU traffic.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alu_req_*                        ALU request: valid/ready handshake,
//                                    operands and add/sub controls
//   mdv_req_*                        MULDIV request: same handshake plus done
//   mdv_sbf_{0,1}_ena/_nxt           MULDIV write port for shared buffers
//   sbf_{0,1}_r                      shared buffer contents
//   flush_pulse                      aborts MULDIV ownership
//   adder_op1/op2/add/sub            muxed operands/controls to the adder
//   mdv_busy                         datapath currently locked to MULDIV
// ---------------------------------------------------------------------------
module e203_exu_alu_dpath_arb #(
  parameter int ADDER_W    = 35,
  parameter int SBF_W      = 33,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               alu_req_valid,
  output logic               alu_req_ready,
  input  logic [ADDER_W-1:0] alu_req_op1,
  input  logic [ADDER_W-1:0] alu_req_op2,
  input  logic               alu_req_add,
  input  logic               alu_req_sub,

  input  logic               mdv_req_valid,
  output logic               mdv_req_ready,
  input  logic               mdv_req_done,
  input  logic [ADDER_W-1:0] mdv_req_op1,
  input  logic [ADDER_W-1:0] mdv_req_op2,
  input  logic               mdv_req_add,
  input  logic               mdv_req_sub,

  input  logic               mdv_sbf_0_ena,
  input  logic [SBF_W-1:0]   mdv_sbf_0_nxt,
  input  logic               mdv_sbf_1_ena,
  input  logic [SBF_W-1:0]   mdv_sbf_1_nxt,
  output logic [SBF_W-1:0]   sbf_0_r,
  output logic [SBF_W-1:0]   sbf_1_r,

  input  logic               flush_pulse,

  output logic [ADDER_W-1:0] adder_op1,
  output logic [ADDER_W-1:0] adder_op2,
  output logic               adder_add,
  output logic               adder_sub,

  output logic               mdv_busy
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MDV_OWN = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  logic             starve_hit;
  logic             alu_grant;
  logic             mdv_grant;

  assign starve_hit = (starve_cnt == CNT_MAX);

  // Grant decision and lock FSM.
  // In IDLE, the ALU normally wins ties. Once MULDIV has lost STARVE_MAX
  // times in a row, the priority flips to MULDIV for that cycle.
  // In MDV_OWN, the ALU is locked out completely. MULDIV is granted whenever
  // it asks. A flush still lets the flush cycle's MULDIV grant through; it
  // only drops the lock for the following cycle.
  always_comb begin
    alu_grant = 1'b0;
    mdv_grant = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        alu_grant = alu_req_valid & ~(mdv_req_valid & starve_hit);
        mdv_grant = mdv_req_valid & (~alu_req_valid | starve_hit);
        if (mdv_grant && !mdv_req_done) begin
          state_nxt = MDV_OWN;
        end
      end
      MDV_OWN: begin
        mdv_grant = mdv_req_valid;
        if (flush_pulse || (mdv_grant && mdv_req_done)) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The starvation count tracks consecutive IDLE cycles in which MULDIV was
  // waiting but the ALU took the adder. Any MULDIV grant resets the count,
  // and so does MULDIV dropping its request.
  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (mdv_grant || !mdv_req_valid) begin
      starve_cnt_nxt = '0;
    end else if ((state == IDLE) && alu_grant && !starve_hit) begin
      starve_cnt_nxt = starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // Adder operand mux. When nobody holds a grant, the operands are forced to
  // zero so that the adder does not toggle.
  always_comb begin
    adder_op1 = '0;
    adder_op2 = '0;
    adder_add = 1'b0;
    adder_sub = 1'b0;
    if (alu_grant) begin
      adder_op1 = alu_req_op1;
      adder_op2 = alu_req_op2;
      adder_add = alu_req_add;
      adder_sub = alu_req_sub;
    end else if (mdv_grant) begin
      adder_op1 = mdv_req_op1;
      adder_op2 = mdv_req_op2;
      adder_add = mdv_req_add;
      adder_sub = mdv_req_sub;
    end
  end

  // Shared buffers belong to MULDIV. Only a granted MULDIV cycle may update
  // them. Their contents survive done and flush, so the sequencer can read
  // back its final result afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbf_0_r <= '0;
      sbf_1_r <= '0;
    end else begin
      if (mdv_grant && mdv_sbf_0_ena) begin
        sbf_0_r <= mdv_sbf_0_nxt;
      end
      if (mdv_grant && mdv_sbf_1_ena) begin
        sbf_1_r <= mdv_sbf_1_nxt;
      end
    end
  end

  assign alu_req_ready = alu_grant;
  assign mdv_req_ready = mdv_grant;
  assign mdv_busy      = (state == MDV_OWN);

  // The two grants must never be asserted together.
  grant_exclusive_a : assert property (
    @(posedge clk) disable iff (!rst_n) !(alu_req_ready && mdv_req_ready)
  );

endmodule

// File: tb/tb_e203_exu_alu_dpath_arb.sv
// ---------------------------------------------------------------------------
// tb_e203_exu_alu_dpath_arb
//
// Self-checking bench for the EXU ALU datapath arbiter. It runs in four
// parts:
//   - A table of single-cycle vectors applied from IDLE.
//   - Hand-written sequences covering:
//       * the 17-cycle MULDIV lock
//       * the starvation limit
//       * a flush that aborts the lock
//       * reset asserted mid-operation
//   - A randomized run checked against a cycle-level reference model.
//
// The reference model is expressed in terms of an ownership flag, a count
// of MULDIV losses, and the two buffer values.
// ---------------------------------------------------------------------------
module tb_e203_exu_alu_dpath_arb;

  localparam int AW   = 35;
  localparam int SW   = 33;
  localparam int SMAX = 4;

  logic          clk;
  logic          rst_n;
  logic          alu_req_valid;
  logic          alu_req_ready;
  logic [AW-1:0] alu_req_op1;
  logic [AW-1:0] alu_req_op2;
  logic          alu_req_add;
  logic          alu_req_sub;
  logic          mdv_req_valid;
  logic          mdv_req_ready;
  logic          mdv_req_done;
  logic [AW-1:0] mdv_req_op1;
  logic [AW-1:0] mdv_req_op2;
  logic          mdv_req_add;
  logic          mdv_req_sub;
  logic          mdv_sbf_0_ena;
  logic [SW-1:0] mdv_sbf_0_nxt;
  logic          mdv_sbf_1_ena;
  logic [SW-1:0] mdv_sbf_1_nxt;
  logic [SW-1:0] sbf_0_r;
  logic [SW-1:0] sbf_1_r;
  logic          flush_pulse;
  logic [AW-1:0] adder_op1;
  logic [AW-1:0] adder_op2;
  logic          adder_add;
  logic          adder_sub;
  logic          mdv_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          alu_v;
    logic [AW-1:0] alu_op1;
    logic [AW-1:0] alu_op2;
    logic          alu_add;
    logic          alu_sub;
    logic          mdv_v;
    logic          mdv_done;
    logic [AW-1:0] mdv_op1;
    logic [AW-1:0] mdv_op2;
    logic          mdv_add;
    logic          mdv_sub;
    logic          ena0;
    logic [SW-1:0] nxt0;
    logic          ena1;
    logic [SW-1:0] nxt1;
    logic          flush;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic          exp_alu_rdy;
    logic          exp_mdv_rdy;
    logic [AW-1:0] exp_op1;
    logic [AW-1:0] exp_op2;
    logic          exp_add;
    logic          exp_sub;
  } vec_t;

  e203_exu_alu_dpath_arb #(
    .ADDER_W   (AW),
    .SBF_W     (SW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_req_valid(alu_req_valid),
    .alu_req_ready(alu_req_ready),
    .alu_req_op1  (alu_req_op1),
    .alu_req_op2  (alu_req_op2),
    .alu_req_add  (alu_req_add),
    .alu_req_sub  (alu_req_sub),
    .mdv_req_valid(mdv_req_valid),
    .mdv_req_ready(mdv_req_ready),
    .mdv_req_done (mdv_req_done),
    .mdv_req_op1  (mdv_req_op1),
    .mdv_req_op2  (mdv_req_op2),
    .mdv_req_add  (mdv_req_add),
    .mdv_req_sub  (mdv_req_sub),
    .mdv_sbf_0_ena(mdv_sbf_0_ena),
    .mdv_sbf_0_nxt(mdv_sbf_0_nxt),
    .mdv_sbf_1_ena(mdv_sbf_1_ena),
    .mdv_sbf_1_nxt(mdv_sbf_1_nxt),
    .sbf_0_r      (sbf_0_r),
    .sbf_1_r      (sbf_1_r),
    .flush_pulse  (flush_pulse),
    .adder_op1    (adder_op1),
    .adder_op2    (adder_op2),
    .adder_add    (adder_add),
    .adder_sub    (adder_sub),
    .mdv_busy     (mdv_busy)
  );

  // 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An all-quiet cycle: nothing valid, no writes, no flush.
  function automatic stim_t idleStim();
    stim_t s;
    s.alu_v = 1'b0;  s.alu_op1 = '0;  s.alu_op2 = '0;
    s.alu_add = 1'b0; s.alu_sub = 1'b0;
    s.mdv_v = 1'b0;  s.mdv_done = 1'b0;
    s.mdv_op1 = '0;  s.mdv_op2 = '0;
    s.mdv_add = 1'b0; s.mdv_sub = 1'b0;
    s.ena0 = 1'b0;   s.nxt0 = '0;
    s.ena1 = 1'b0;   s.nxt1 = '0;
    s.flush = 1'b0;
    return s;
  endfunction

  // Table vector builder. MULDIV always asserts done here, so a MULDIV grant
  // never locks the datapath and every vector starts from IDLE.
  function automatic vec_t mkVec(
    input logic av, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
    input logic aa, input logic as_,
    input logic mv, input logic [AW-1:0] m1, input logic [AW-1:0] m2,
    input logic ma, input logic ms,
    input logic ear, input logic emr, input logic [AW-1:0] e1,
    input logic [AW-1:0] e2, input logic ea, input logic es);
    vec_t v;
    v.s = idleStim();
    v.s.alu_v = av; v.s.alu_op1 = a1; v.s.alu_op2 = a2;
    v.s.alu_add = aa; v.s.alu_sub = as_;
    v.s.mdv_v = mv; v.s.mdv_done = 1'b1; v.s.mdv_op1 = m1; v.s.mdv_op2 = m2;
    v.s.mdv_add = ma; v.s.mdv_sub = ms;
    v.exp_alu_rdy = ear; v.exp_mdv_rdy = emr;
    v.exp_op1 = e1; v.exp_op2 = e2; v.exp_add = ea; v.exp_sub = es;
    return v;
  endfunction

  // Drive one cycle's worth of inputs onto the DUT.
  task automatic applyStimulus(input stim_t s);
    alu_req_valid = s.alu_v;
    alu_req_op1   = s.alu_op1;
    alu_req_op2   = s.alu_op2;
    alu_req_add   = s.alu_add;
    alu_req_sub   = s.alu_sub;
    mdv_req_valid = s.mdv_v;
    mdv_req_done  = s.mdv_done;
    mdv_req_op1   = s.mdv_op1;
    mdv_req_op2   = s.mdv_op2;
    mdv_req_add   = s.mdv_add;
    mdv_req_sub   = s.mdv_sub;
    mdv_sbf_0_ena = s.ena0;
    mdv_sbf_0_nxt = s.nxt0;
    mdv_sbf_1_ena = s.ena1;
    mdv_sbf_1_nxt = s.nxt1;
    flush_pulse   = s.flush;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(idleStim());
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    clockEdge();
  endtask

  function automatic logic [127:0] adderBus(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b,
                                            input logic ad,
                                            input logic sb);
    return 128'({a, b, ad, sb});
  endfunction

  // Reference model state.
  bit            m_owned;
  int            m_losses;
  logic [SW-1:0] m_sbf0;
  logic [SW-1:0] m_sbf1;

  vec_t  vecs[8];
  stim_t s;

  initial begin
    rst_n = 1'b0;
    applyStimulus(idleStim());

    // ------------------------------------------------------------------
    // Reset state.
    doReset();
    checkOutput("reset_busy", 128'(mdv_busy), 128'(1'b0));
    checkOutput("reset_sbf0", 128'(sbf_0_r), 128'(0));
    checkOutput("reset_sbf1", 128'(sbf_1_r), 128'(0));
    checkOutput("reset_readies", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b00));

    // ------------------------------------------------------------------
    // Table-driven single-cycle vectors, applied from IDLE.
    vecs[0] = mkVec(1, 35'd5, 35'd3, 1, 0,
                    0, 35'd0, 35'd0, 0, 0,
                    1, 0, 35'd5, 35'd3, 1, 0);
    vecs[1] = mkVec(0, 35'd0, 35'd0, 0, 0,
                    0, 35'd0, 35'd0, 0, 0,
                    0, 0, 35'd0, 35'd0, 0, 0);
    vecs[2] = mkVec(0, 35'd0, 35'd0, 0, 0,
                    1, 35'h1_0000_00AA, 35'h0_5555_5555, 0, 1,
                    0, 1, 35'h1_0000_00AA, 35'h0_5555_5555, 0, 1);
    vecs[3] = mkVec(1, 35'd7, 35'd9, 1, 0,
                    1, 35'd100, 35'd200, 1, 0,
                    1, 0, 35'd7, 35'd9, 1, 0);
    vecs[4] = mkVec(0, 35'd7, 35'd9, 1, 0,
                    0, 35'd100, 35'd200, 1, 0,
                    0, 0, 35'd0, 35'd0, 0, 0);
    vecs[5] = mkVec(1, 35'h7_FFFF_FFFF, 35'd1, 0, 1,
                    0, 35'd0, 35'd0, 0, 0,
                    1, 0, 35'h7_FFFF_FFFF, 35'd1, 0, 1);
    vecs[6] = mkVec(0, 35'h2_AAAA_AAAA, 35'h5_5555_5555, 1, 1,
                    0, 35'h3_3333_3333, 35'h4_4444_4444, 1, 1,
                    0, 0, 35'd0, 35'd0, 0, 0);
    vecs[7] = mkVec(0, 35'd0, 35'd0, 0, 0,
                    1, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 1, 0,
                    0, 1, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 1, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].s);
      #1;
      checkOutput($sformatf("vec%0d_ready", i),
                  128'({alu_req_ready, mdv_req_ready}),
                  128'({vecs[i].exp_alu_rdy, vecs[i].exp_mdv_rdy}));
      checkOutput($sformatf("vec%0d_adder", i),
                  adderBus(adder_op1, adder_op2, adder_add, adder_sub),
                  adderBus(vecs[i].exp_op1, vecs[i].exp_op2,
                           vecs[i].exp_add, vecs[i].exp_sub));
      clockEdge();
      checkOutput($sformatf("vec%0d_busy", i), 128'(mdv_busy), 128'(1'b0));
    end

    // ------------------------------------------------------------------
    // 17-cycle MULDIV lock, with shared buffer writes.
    doReset();
    s = idleStim();
    s.mdv_v = 1'b1; s.mdv_op1 = 35'h11; s.mdv_add = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lock_start_ready", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b01));
    clockEdge();
    checkOutput("lock_start_busy", 128'(mdv_busy), 128'(1'b1));
    for (int c = 2; c <= 16; c++) begin
      s = idleStim();
      s.alu_v = 1'b1; s.alu_op1 = 35'd1; s.alu_add = 1'b1;
      s.mdv_v = (c != 3);
      s.ena0  = (c == 2 || c == 3);
      s.nxt0  = (c == 2) ? 33'h1_2345_6789 : 33'h0_0BAD_BEEF;
      applyStimulus(s);
      #1;
      checkOutput($sformatf("lock_c%0d_ready", c),
                  128'({alu_req_ready, mdv_req_ready}),
                  128'({1'b0, (c != 3)}));
      clockEdge();
      checkOutput($sformatf("lock_c%0d_busy", c), 128'(mdv_busy), 128'(1'b1));
      if (c == 2 || c == 3) begin
        checkOutput($sformatf("lock_c%0d_sbf0", c), 128'(sbf_0_r),
                    128'(33'h1_2345_6789));
      end
    end
    s = idleStim();
    s.alu_v = 1'b1; s.mdv_v = 1'b1; s.mdv_done = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lock_done_ready", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b01));
    clockEdge();
    checkOutput("lock_release_busy", 128'(mdv_busy), 128'(1'b0));
    s = idleStim();
    s.alu_v = 1'b1; s.alu_op1 = 35'd42; s.alu_add = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("lock_after_alu_ready", 128'(alu_req_ready), 128'(1'b1));
    clockEdge();

    // ------------------------------------------------------------------
    // Starvation limit: ALU wins 4 times, then MULDIV takes the 5th.
    doReset();
    s = idleStim();
    s.alu_v = 1'b1; s.alu_op1 = 35'd1; s.alu_op2 = 35'd2; s.alu_add = 1'b1;
    s.mdv_v = 1'b1; s.mdv_op1 = 35'd3; s.mdv_op2 = 35'd4; s.mdv_sub = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(s);
      #1;
      checkOutput($sformatf("starve_c%0d_ready", c),
                  128'({alu_req_ready, mdv_req_ready}),
                  128'({(c < 5), (c == 5)}));
      if (c == 5) begin
        checkOutput("starve_c5_adder",
                    adderBus(adder_op1, adder_op2, adder_add, adder_sub),
                    adderBus(35'd3, 35'd4, 1'b0, 1'b1));
      end
      clockEdge();
      checkOutput($sformatf("starve_c%0d_busy", c), 128'(mdv_busy),
                  128'(c == 5));
    end
    s.mdv_done = 1'b1;
    applyStimulus(s);
    clockEdge();
    checkOutput("starve_done_busy", 128'(mdv_busy), 128'(1'b0));
    s.mdv_done = 1'b0;
    applyStimulus(s);
    #1;
    checkOutput("starve_cleared_ready", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b10));
    clockEdge();

    // ------------------------------------------------------------------
    // Flush on the 10th lock cycle; the buffers survive and the ALU gets in.
    doReset();
    for (int c = 1; c <= 9; c++) begin
      s = idleStim();
      s.mdv_v = 1'b1;
      s.ena0 = (c == 2); s.nxt0 = 33'h1_0000_0001;
      s.ena1 = (c == 2); s.nxt1 = 33'h0_CAFE_F00D;
      applyStimulus(s);
      clockEdge();
    end
    checkOutput("flush_pre_busy", 128'(mdv_busy), 128'(1'b1));
    s = idleStim();
    s.mdv_v = 1'b1; s.alu_v = 1'b1; s.flush = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("flush_cycle_ready", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b01));
    clockEdge();
    checkOutput("flush_busy", 128'(mdv_busy), 128'(1'b0));
    s = idleStim();
    s.alu_v = 1'b1; s.alu_op2 = 35'd77; s.alu_sub = 1'b1;
    applyStimulus(s);
    #1;
    checkOutput("flush_alu_ready", 128'(alu_req_ready), 128'(1'b1));
    checkOutput("flush_sbf0", 128'(sbf_0_r), 128'(33'h1_0000_0001));
    checkOutput("flush_sbf1", 128'(sbf_1_r), 128'(33'h0_CAFE_F00D));
    clockEdge();

    // ------------------------------------------------------------------
    // Reset asserted while MULDIV owns the datapath.
    s = idleStim();
    s.mdv_v = 1'b1;
    s.ena0 = 1'b1; s.nxt0 = 33'h1_FFFF_0000;
    s.ena1 = 1'b1; s.nxt1 = 33'h0_1234_5678;
    applyStimulus(s);
    clockEdge();
    checkOutput("rst_mid_busy_before", 128'(mdv_busy), 128'(1'b1));
    checkOutput("rst_mid_sbf0_before", 128'(sbf_0_r), 128'(33'h1_FFFF_0000));
    applyStimulus(idleStim());
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 128'(mdv_busy), 128'(1'b0));
    checkOutput("rst_mid_sbf", 128'({sbf_0_r, sbf_1_r}), 128'(0));
    checkOutput("rst_mid_adder",
                adderBus(adder_op1, adder_op2, adder_add, adder_sub), 128'(0));
    checkOutput("rst_mid_readies", 128'({alu_req_ready, mdv_req_ready}),
                128'(2'b00));
    #2 rst_n = 1'b1;
    clockEdge();

    // ------------------------------------------------------------------
    // Randomized traffic against the reference model.
    doReset();
    m_owned = 1'b0; m_losses = 0; m_sbf0 = '0; m_sbf1 = '0;
    for (int n = 0; n < 1500; n++) begin
      bit            alu_win;
      bit            mdv_win;
      logic [AW-1:0] e1;
      logic [AW-1:0] e2;
      logic          ea;
      logic          es;
      s = idleStim();
      s.alu_v    = ($urandom_range(3, 0) != 0);
      s.alu_op1  = AW'({$urandom(), $urandom()});
      s.alu_op2  = AW'({$urandom(), $urandom()});
      s.alu_add  = 1'($urandom());
      s.alu_sub  = 1'($urandom());
      s.mdv_v    = 1'($urandom());
      s.mdv_done = ($urandom_range(7, 0) == 0);
      s.mdv_op1  = AW'({$urandom(), $urandom()});
      s.mdv_op2  = AW'({$urandom(), $urandom()});
      s.mdv_add  = 1'($urandom());
      s.mdv_sub  = 1'($urandom());
      s.ena0     = 1'($urandom());
      s.nxt0     = SW'({$urandom(), $urandom()});
      s.ena1     = 1'($urandom());
      s.nxt1     = SW'({$urandom(), $urandom()});
      s.flush    = ($urandom_range(15, 0) == 0);

      // Who gets the adder this cycle, according to the rules.
      if (m_owned) begin
        alu_win = 1'b0;
        mdv_win = s.mdv_v;
      end else if (s.alu_v && s.mdv_v) begin
        mdv_win = (m_losses >= SMAX);
        alu_win = !mdv_win;
      end else begin
        alu_win = s.alu_v;
        mdv_win = s.mdv_v;
      end
      e1 = alu_win ? s.alu_op1 : (mdv_win ? s.mdv_op1 : '0);
      e2 = alu_win ? s.alu_op2 : (mdv_win ? s.mdv_op2 : '0);
      ea = alu_win ? s.alu_add : (mdv_win ? s.mdv_add : 1'b0);
      es = alu_win ? s.alu_sub : (mdv_win ? s.mdv_sub : 1'b0);

      applyStimulus(s);
      #1;
      checkOutput($sformatf("rand%0d_ready", n),
                  128'({alu_req_ready, mdv_req_ready}),
                  128'({alu_win, mdv_win}));
      checkOutput($sformatf("rand%0d_adder", n),
                  adderBus(adder_op1, adder_op2, adder_add, adder_sub),
                  adderBus(e1, e2, ea, es));

      // Advance the model by one cycle.
      if (mdv_win && s.ena0) m_sbf0 = s.nxt0;
      if (mdv_win && s.ena1) m_sbf1 = s.nxt1;
      if (!m_owned && alu_win && s.mdv_v) begin
        m_losses = (m_losses + 1 > SMAX) ? SMAX : m_losses + 1;
      end else begin
        m_losses = 0;
      end
      if (!m_owned) begin
        if (mdv_win && !s.mdv_done) m_owned = 1'b1;
      end else if (s.flush || (mdv_win && s.mdv_done)) begin
        m_owned = 1'b0;
      end

      clockEdge();
      checkOutput($sformatf("rand%0d_busy", n), 128'(mdv_busy), 128'(m_owned));
      checkOutput($sformatf("rand%0d_sbf0", n), 128'(sbf_0_r), 128'(m_sbf0));
      checkOutput($sformatf("rand%0d_sbf1", n), 128'(sbf_1_r), 128'(m_sbf1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_exu_alu_dpath_arb.md
Name: e203_exu_alu_dpath_arb

Overview:
- Owns and arbitrates the shared 35-bit adder and the two 33-bit shared buffers (sbf_0/sbf_1) inside the EXU ALU.
- Arbitrates between single-cycle ALU requests and the multi-cycle MULDIV sequencer.
- Locks the datapath to MULDIV for the full 17/33-cycle operation and releases it on done or flush.
- Has an anti-starvation counter so a pending MULDIV start cannot be blocked forever by back-to-back ALU traffic.

Parameters:
- ADDER_W, 35, shared adder operand/result width.
- SBF_W, 33, width of each shared buffer register.
- STARVE_MAX, 4, consecutive cycles a MULDIV start may lose to ALU before forced priority.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- alu_req_valid  input  1  ALU wants adder this cycle
- alu_req_ready  output  1  ALU granted this cycle
- alu_req_op1  input  ADDER_W  ALU operand 1
- alu_req_op2  input  ADDER_W  ALU operand 2
- alu_req_add  input  1  ALU add
- alu_req_sub  input  1  ALU subtract
- mdv_req_valid  input  1  MULDIV wants adder (start or continuing step)
- mdv_req_ready  output  1  MULDIV granted this cycle
- mdv_req_done  input  1  last MULDIV step this cycle; releases lock
- mdv_req_op1  input  ADDER_W  MULDIV operand 1
- mdv_req_op2  input  ADDER_W  MULDIV operand 2
- mdv_req_add  input  1  MULDIV add
- mdv_req_sub  input  1  MULDIV subtract
- mdv_sbf_0_ena  input  1  sbf_0 write enable from MULDIV
- mdv_sbf_0_nxt  input  SBF_W  sbf_0 next value
- mdv_sbf_1_ena  input  1  sbf_1 write enable from MULDIV
- mdv_sbf_1_nxt  input  SBF_W  sbf_1 next value
- sbf_0_r  output  SBF_W  sbf_0 current value
- sbf_1_r  output  SBF_W  sbf_1 current value
- flush_pulse  input  1  pipeline flush; aborts MULDIV ownership
- adder_op1  output  ADDER_W  to adder
- adder_op2  output  ADDER_W  to adder
- adder_add  output  1  to adder
- adder_sub  output  1  to adder
- mdv_busy  output  1  datapath locked to MULDIV

Behaviour:
- Reset (async, rst_n low): state=IDLE, starve_cnt=0, sbf_0_r=0, sbf_1_r=0, mdv_busy=0. Grants are combinational and therefore 0 while the valids are 0.
- States: IDLE, MDV_OWN. mdv_busy = (state==MDV_OWN).
- IDLE grant rules:
  - If only ALU is valid, ALU is granted.
  - If only MULDIV is valid, MULDIV is granted.
  - If both are valid, ALU wins unless starve_cnt==STARVE_MAX, in which case MULDIV wins.
- IDLE transition: a MULDIV grant with mdv_req_done=0 moves to MDV_OWN next cycle. A grant with done=1 in the same cycle stays IDLE.
- MDV_OWN:
  - alu_req_ready=0; mdv_req_ready=mdv_req_valid.
  - Granted done=1 returns to IDLE next cycle.
  - flush_pulse returns to IDLE next cycle regardless of done; the flush cycle's grant is still issued.
- flush_pulse in IDLE has no effect on grants.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when in IDLE, mdv_req_valid=1 and ALU is granted.
  - Clears whenever MULDIV is granted or mdv_req_valid=0.
- Adder mux: the granted requester's op1/op2/add/sub drive the adder outputs. With no grant, all adder outputs are 0 (operand gating for power). Zero latency; the adder result returns to requesters outside this block.
- Shared buffers: written on clk only when MULDIV is granted that cycle and its *_ena=1; otherwise they hold.
  - sbf_0 and sbf_1 are independent.
  - Values are not cleared on flush or done.
  - An ena asserted without a grant is ignored.
- Grant exclusivity: alu_req_ready & mdv_req_ready is never 1.
- Reset asserted mid-operation immediately forces IDLE and clears the buffers.

Test Plan:
- Reset then alu_req_valid=1, op1=5, op2=3, add=1 -> same cycle alu_req_ready=1, adder_op1=5, adder_op2=3, adder_add=1, mdv_busy=0.
- mdv_req_valid=1 (done=0) in IDLE with ALU idle -> mdv_req_ready=1 that cycle; mdv_busy=1 next. ALU valid while busy gets ready=0. Done=1 on cycle 17 -> mdv_busy=0 on cycle 18.
- ALU and MULDIV both valid continuously, STARVE_MAX=4 -> ALU granted 4 cycles; MULDIV granted on the 5th cycle; starve_cnt back to 0.
- Busy MULDIV with sbf_0_ena=1, nxt=0x1_2345_6789 -> sbf_0_r=0x1_2345_6789 next cycle. Same ena with mdv_req_valid=0 -> no change.
- flush_pulse=1 on cycle 10 of MDV_OWN -> mdv_busy=0 on cycle 11. A waiting ALU is granted on cycle 11. sbf values are retained.
- rst_n low while in MDV_OWN -> immediately mdv_busy=0, sbf_0_r=sbf_1_r=0, all adder outputs 0 when no valids.
